if_fetch_unit: RTL
==================

Name: if_fetch_unit

Overview:
Instruction-fetch stage directly upstream of the IF/ID pipeline register. Owns the PC, selects the next PC (sequential, branch or jump redirect) and runs a single-outstanding request/response handshake to instruction memory. Presents {instruction, pc+4, valid} to IF/ID and honours the hazard-unit stall. Substitutes a NOP bubble (32'h0) whenever no valid instruction is available.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
PC_INC, 4, byte increment for sequential fetch

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
stall  in  1  hazard-unit stall; the same signal drives IF/ID stall
jump  in  1  jump resolved in ID; redirect to jump_target
jump_target  in  32  jump destination
branch_taken  in  1  branch resolved taken in ID (reg_equal & branch); redirect to branch_target
branch_target  in  32  branch destination
imem_req  out  1  fetch request valid
imem_addr  out  32  fetch address, word aligned
imem_ready  in  1  memory accepts request this cycle (req & ready = handshake)
imem_rvalid  in  1  response data valid (exactly one per accepted request, in order)
imem_rdata  in  32  fetched instruction
instruction_out  out  32  instruction to IF/ID; 32'h0 when if_valid=0
pc_next_out  out  32  PC of instruction_out + PC_INC; 32'h0 when if_valid=0
if_valid  out  1  instruction_out is a real instruction
fetch_bubble  out  1  high when IF/ID is loading a bubble because fetch is late (!if_valid & !stall)

Behaviour:
- Reset (reset=0, asynchronous): pc=RESET_PC, state=IDLE, hold buffer empty, discard=0; imem_req=0, instruction_out=0, pc_next_out=0, if_valid=0, fetch_bubble=0. Fetching starts on the first rising edge after reset releases.
- State: IDLE (nothing outstanding), WAIT (one request accepted, response pending). Hold buffer HB {instr, pc+4, full} is separate from state.
- imem_req=1 when (IDLE, or WAIT with imem_rvalid this cycle) and HB not full and !stall. imem_addr=pc.
- Handshake (req & ready): pc <= pc + PC_INC (32-bit wrap, 32'hFFFF_FFFC -> 0), state <= WAIT. req held with address stable until ready.
- Response (WAIT & rvalid & !discard): drives instruction_out=rdata, pc_next_out=resp_pc+PC_INC, if_valid=1 combinationally the same cycle. If stall=1 that cycle, capture into HB (full<=1). State returns to IDLE unless a new handshake occurs in the same cycle (back-to-back: 1 instr/cycle with 1-cycle memory).
- HB full: outputs driven from HB, if_valid=1; no new request; HB clears on the first cycle with stall=0 (IF/ID consumes it).
- Redirect (jump | branch_taken, jump has priority if both): pc <= target on that edge; HB cleared; current output suppressed (if_valid=0, outputs 0) since IF/ID flushes that cycle; if state=WAIT and no rvalid this cycle, discard<=1. Redirect overrides stall for PC update.
- discard=1: next rvalid is dropped (if_valid stays 0), discard<=0, state<=IDLE. A new request is not issued in the drop cycle.
- Redirect coincident with handshake: request is counted as issued but its response is discarded; pc <= target (not pc+4).
- Non-aligned targets: low 2 bits forced to 0 on imem_addr.
- Reset mid-WAIT: outstanding response ignored; memory side is reset by the same reset.

Optional Feature:
FETCH_PERF_EN: when defined, adds outputs perf_fetch_cnt[31:0] (increments per delivered valid instruction consumed with stall=0) and perf_bubble_cnt[31:0] (increments each cycle fetch_bubble=1); both reset to 0, wrap at 2^32. When undefined, ports and counters are absent; all other behaviour identical.

Test Plan:
- Reset, RESET_PC=0, 1-cycle memory, ready=1 -> addr 0,4,8,... on consecutive cycles; pc_next_out 4,8,12 one cycle after each request; if_valid=1 steady state.
- ready low 3 cycles on addr 0x8 -> imem_addr holds 0x8, req stays 1; fetch_bubble=1 for those cycles; pc unchanged.
- stall=1 when response for 0x10 arrives -> HB holds it; outputs stable over 4 stall cycles; no new req; on release pc_next_out=0x14 for one cycle, then 0x14 fetched.
- branch_taken=1, branch_target=0x100 while WAIT for 0x20 -> 0x20 response dropped (if_valid=0), next request addr=0x100.
- jump=1 and branch_taken=1 simultaneously, targets 0x200/0x300 -> next fetch from 0x200.
- reset=0 asserted mid-WAIT -> outputs 0 immediately (asynchronous); after release first request addr=RESET_PC.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage feeding IF/ID: owns the PC, redirects on jump/branch, single-outstanding imem handshake.
// Define FETCH_PERF_EN to add the perf_fetch_cnt / perf_bubble_cnt counters.
`timescale 1ns/1ps
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_INC   = 32'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction_out,
    output logic [31:0] pc_next_out,
    output logic        if_valid,
    output logic        fetch_bubble
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_bubble_cnt
`endif
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    logic [0:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_resp_pc;
    logic [31:0] r_hb_instr;
    logic [31:0] r_hb_pc_next;
    logic        r_hb_full;
    logic        r_discard;

    logic        w_redirect;
    logic [31:0] w_target;
    logic        w_rsp_any;
    logic        w_rsp_live;
    logic        w_req;
    logic        w_hs;

    assign w_redirect = jump | branch_taken;
    assign w_target   = jump ? jump_target : branch_target;
    assign w_rsp_any  = (r_state == ST_WAIT) & imem_rvalid;
    assign w_rsp_live = w_rsp_any & ~r_discard;
    // A dropped response frees the memory port only on the following cycle.
    assign w_req      = ((r_state == ST_IDLE) | w_rsp_live) & ~r_hb_full & ~stall & reset;
    assign w_hs       = w_req & imem_ready;

    assign imem_req   = w_req;
    assign imem_addr  = {r_pc[31:2], 2'b00};

    always_comb begin
        instruction_out = 32'h0;
        pc_next_out     = 32'h0;
        if_valid        = 1'b0;
        if (reset && !w_redirect) begin
            if (r_hb_full) begin
                instruction_out = r_hb_instr;
                pc_next_out     = r_hb_pc_next;
                if_valid        = 1'b1;
            end else if (w_rsp_live) begin
                instruction_out = imem_rdata;
                pc_next_out     = r_resp_pc + PC_INC;
                if_valid        = 1'b1;
            end
        end
    end

    assign fetch_bubble = reset & ~if_valid & ~stall;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_pc      <= RESET_PC;
            r_hb_full <= 1'b0;
            r_discard <= 1'b0;
        end else begin
            if (w_redirect) begin
                r_pc <= {w_target[31:2], 2'b00};
            end else if (w_hs) begin
                r_pc <= r_pc + PC_INC;
            end

            if (w_hs) begin
                r_state <= ST_WAIT;
            end else if (w_rsp_any) begin
                r_state <= ST_IDLE;
            end

            // The hold buffer drains on the first unstalled cycle; a redirect flushes it.
            if (w_redirect) begin
                r_hb_full <= 1'b0;
            end else if (r_hb_full) begin
                r_hb_full <= stall;
            end else if (w_rsp_live && stall) begin
                r_hb_full <= 1'b1;
            end

            if (w_redirect && (w_hs || (r_state == ST_WAIT && !imem_rvalid))) begin
                r_discard <= 1'b1;
            end else if (w_rsp_any) begin
                r_discard <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_hs) begin
            r_resp_pc <= r_pc;
        end
        if (w_rsp_live && stall && !r_hb_full && !w_redirect) begin
            r_hb_instr   <= imem_rdata;
            r_hb_pc_next <= r_resp_pc + PC_INC;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] r_perf_fetch_cnt;
    logic [31:0] r_perf_bubble_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_perf_fetch_cnt  <= 32'h0;
            r_perf_bubble_cnt <= 32'h0;
        end else begin
            if (if_valid && !stall) begin
                r_perf_fetch_cnt <= r_perf_fetch_cnt + 32'd1;
            end
            if (fetch_bubble) begin
                r_perf_bubble_cnt <= r_perf_bubble_cnt + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt  = r_perf_fetch_cnt;
    assign perf_bubble_cnt = r_perf_bubble_cnt;
`endif

endmodule
